instr_decoder: RTL and testbench

Registered RV32I instruction decode stage that feeds the ALU.
- Accepts raw 32-bit instruction words on a valid/ready handshake.
- Classifies each word into the ALU's instr_type encoding and extracts funct3_, funct7_, register indices and the sign-extended immediate.
- Presents results on a valid/ready output with a 2-entry buffer (output register plus skid register), so it sustains one instruction per cycle under backpressure.
- Sits between instruction fetch and the register file / ALU.

---
 rtl/instr_decoder_if.sv | 42 ++++
 rtl/instr_decoder.sv | 176 +++++++++++++++++
 tb/tb_instr_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/instr_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder_if
//  Description : Handshake and decoded-field bundle between instruction fetch,
//                the instr_decoder stage and the register file / ALU.
//                master = environment side (drives the word in, accepts out)
//                slave  = decoder side
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_decoder_if #(
  parameter int CNT_W = 16
);
  // Upstream word handshake
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  // Downstream decoded handshake
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       instr_type;
  logic [2:0]       funct3_;
  logic [6:0]       funct7_;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [31:0]      imm;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, instr_type, funct3_, funct7_,
           rs1, rs2, rd, imm, illegal, illegal_count
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, instr_type, funct3_, funct7_,
           rs1, rs2, rd, imm, illegal, illegal_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Registered RV32I decode stage. Classifies each accepted word
//                into the ALU instr_type encoding, extracts register indices,
//                funct fields and the sign-extended immediate. Output side is
//                a 2-entry buffer (output register O + skid register S) so the
//                stage sustains one word per cycle with a registered in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  instr_decoder_if.slave bus
);

  // ALU instr_type encoding
  localparam logic [3:0] c_TYPE_R = 4'd0;
  localparam logic [3:0] c_TYPE_I = 4'd1;
  localparam logic [3:0] c_TYPE_S = 4'd2;
  localparam logic [3:0] c_TYPE_B = 4'd3;
  localparam logic [3:0] c_TYPE_U = 4'd4;
  localparam logic [3:0] c_TYPE_J = 4'd5;
  localparam logic [3:0] c_TYPE_N = 4'd7;

  // RV32I major opcodes
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [3:0]  itype;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Pure decode of one word; fields not used by the format stay zero.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.itype   = c_TYPE_N;
    d.illegal = 1'b1;
    case (w[6:0])
      c_OP_REG: begin
        d.itype = c_TYPE_R; d.illegal = 1'b0;
        d.f3 = w[14:12]; d.f7 = w[31:25];
        d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
      end
      c_OP_IMM, c_OP_LOAD, c_OP_JALR: begin
        d.itype = c_TYPE_I; d.illegal = 1'b0;
        d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rd = w[11:7];
        d.imm = {{20{w[31]}}, w[31:20]};
        // Shift-immediates carry a funct7 (SRAI vs SRLI) in the upper bits
        if ((w[6:0] == c_OP_IMM) && ((w[14:12] == 3'b001) || (w[14:12] == 3'b101)))
          d.f7 = w[31:25];
      end
      c_OP_STORE: begin
        d.itype = c_TYPE_S; d.illegal = 1'b0;
        d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      c_OP_BRANCH: begin
        d.itype = c_TYPE_B; d.illegal = 1'b0;
        d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      c_OP_LUI, c_OP_AUIPC: begin
        d.itype = c_TYPE_U; d.illegal = 1'b0;
        d.rd = w[11:7];
        d.imm = {w[31:12], 12'b0};
      end
      c_OP_JAL: begin
        d.itype = c_TYPE_J; d.illegal = 1'b0;
        d.rd = w[11:7];
        d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction

  dec_t             o_q, o_d;          // output register O
  dec_t             s_q, s_d;          // skid register S
  logic             o_valid_q, o_valid_d;
  logic             s_full_q, s_full_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  dec_t w_dec;
  logic w_accept;
  logic w_drain;

  // Next-state for the O/S buffer pair and the illegal-word counter
  always_comb begin
    w_dec     = decode(bus.instr);
    w_accept  = bus.in_valid & in_ready_q;
    w_drain   = o_valid_q & bus.out_ready;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    s_d       = s_q;
    s_full_d  = s_full_q;
    cnt_d     = cnt_q;

    if (w_drain) begin
      if (s_full_q) begin
        // Oldest buffered word moves up; a same-cycle accept refills S
        o_d      = s_q;
        s_d      = w_dec;
        s_full_d = w_accept;
      end else if (w_accept) begin
        o_d = w_dec;            // reload for full throughput
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (!o_valid_q) begin
        o_d       = w_dec;
        o_valid_d = 1'b1;
      end else begin
        s_d      = w_dec;
        s_full_d = 1'b1;
      end
    end

    if (w_accept && w_dec.illegal && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + c_CNT_ONE;
  end

  // State registers; in_ready is registered from the next skid occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q        <= '0;
      s_q        <= '0;
      o_valid_q  <= 1'b0;
      s_full_q   <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      o_q        <= o_d;
      s_q        <= s_d;
      o_valid_q  <= o_valid_d;
      s_full_q   <= s_full_d;
      in_ready_q <= !s_full_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = o_valid_q;
  assign bus.instr_type    = o_q.itype;
  assign bus.funct3_       = o_q.f3;
  assign bus.funct7_       = o_q.f7;
  assign bus.rs1           = o_q.rs1;
  assign bus.rs2           = o_q.rs2;
  assign bus.rd            = o_q.rd;
  assign bus.imm           = o_q.imm;
  assign bus.illegal       = o_q.illegal;
  assign bus.illegal_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_decoder
//  Description : Self-checking bench for instr_decoder: directed decode table
//                plus hand-written backpressure, reset and saturation cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_decoder_if #(.CNT_W(16)) bus  ();
  instr_decoder_if #(.CNT_W(2))  bus2 ();

  instr_decoder #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  instr_decoder #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  t;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input vec_t v);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".type"},  {28'd0, bus.instr_type}, {28'd0, v.t});
    chk({tag, ".f3"},    {29'd0, bus.funct3_}, {29'd0, v.f3});
    chk({tag, ".f7"},    {25'd0, bus.funct7_}, {25'd0, v.f7});
    chk({tag, ".rs1"},   {27'd0, bus.rs1}, {27'd0, v.rs1});
    chk({tag, ".rs2"},   {27'd0, bus.rs2}, {27'd0, v.rs2});
    chk({tag, ".rd"},    {27'd0, bus.rd}, {27'd0, v.rd});
    chk({tag, ".imm"},   bus.imm, v.imm);
    chk({tag, ".ill"},   {31'd0, bus.illegal}, {31'd0, (v.t == 4'd7)});
  endtask

  initial begin
    //            instr          type  f3    f7       rs1    rs2    rd     imm
    vecs[0]  = '{32'h002081B3, 4'd0, 3'd0, 7'h00, 5'd1,  5'd2,  5'd3,  32'h00000000}; // add x3,x1,x2
    vecs[1]  = '{32'h407352B3, 4'd0, 3'd5, 7'h20, 5'd6,  5'd7,  5'd5,  32'h00000000}; // sra x5,x6,x7
    vecs[2]  = '{32'hFFF00093, 4'd1, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  32'hFFFFFFFF}; // addi x1,x0,-1
    vecs[3]  = '{32'hFE208EE3, 4'd3, 3'd0, 7'h00, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFC}; // beq x1,x2,-4
    vecs[4]  = '{32'h40335293, 4'd1, 3'd5, 7'h20, 5'd6,  5'd0,  5'd5,  32'h00000403}; // srai x5,x6,3
    vecs[5]  = '{32'h80000093, 4'd1, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  32'hFFFFF800}; // addi x1,x0,-2048
    vecs[6]  = '{32'h0081A103, 4'd1, 3'd2, 7'h00, 5'd3,  5'd0,  5'd2,  32'h00000008}; // lw x2,8(x3)
    vecs[7]  = '{32'h000280E7, 4'd1, 3'd0, 7'h00, 5'd5,  5'd0,  5'd1,  32'h00000000}; // jalr x1,0(x5)
    vecs[8]  = '{32'hFE20AE23, 4'd2, 3'd2, 7'h00, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFC}; // sw x2,-4(x1)
    vecs[9]  = '{32'h123452B7, 4'd4, 3'd0, 7'h00, 5'd0,  5'd0,  5'd5,  32'h12345000}; // lui x5,0x12345
    vecs[10] = '{32'hFFFFF097, 4'd4, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  32'hFFFFF000}; // auipc x1,0xFFFFF
    vecs[11] = '{32'h009010EF, 4'd5, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  32'h00001808}; // jal x1,+0x1808
    vecs[12] = '{32'h000010E3, 4'd3, 3'd1, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000800}; // bne x0,x0,+2048
    vecs[13] = '{32'h00000000, 4'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000}; // illegal
    vecs[14] = '{32'h00000000, 4'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000}; // illegal
    vecs[15] = '{32'hFFFFFFFF, 4'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000}; // illegal

    bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.instr = '0; bus2.out_ready = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rst.imm",       bus.imm, 32'd0);
    chk("rst.type",      {28'd0, bus.instr_type}, 32'd0);
    chk("rst.count",     {16'd0, bus.illegal_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ---- decode table, one word at a time, consumer always ready ----
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.instr    = vecs[i].instr;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (vecs[i].t == 4'd7) model_cnt++;
      chk_fields($sformatf("v%0d", i), vecs[i]);
      chk($sformatf("v%0d.count", i), {16'd0, bus.illegal_count}, model_cnt);
    end
    @(negedge clk);
    chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // ---- back-to-back addi then beq, delivered on consecutive cycles ----
    bus.in_valid = 1'b1; bus.instr = vecs[2].instr;
    @(negedge clk);
    bus.instr = vecs[3].instr;
    chk_fields("b2b.first", vecs[2]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_fields("b2b.second", vecs[3]);
    @(negedge clk);
    chk("b2b.drained", {31'd0, bus.out_valid}, 32'd0);

    // ---- backpressure: A in O, B in S, C held off ----
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instr = vecs[0].instr;          // A
    @(negedge clk);
    chk("bp.in_ready_after_A", {31'd0, bus.in_ready}, 32'd1);
    bus.instr = vecs[1].instr;                               // B
    @(negedge clk);
    chk("bp.in_ready_after_B", {31'd0, bus.in_ready}, 32'd0);
    chk_fields("bp.holdA1", vecs[0]);
    bus.instr = vecs[9].instr;                               // C offered
    @(negedge clk);
    chk("bp.C_held", {31'd0, bus.in_ready}, 32'd0);
    chk_fields("bp.holdA2", vecs[0]);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_fields("bp.outB", vecs[1]);
    chk("bp.in_ready_reopen", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);                                          // C accepted here
    bus.in_valid = 1'b0;
    chk_fields("bp.outC", vecs[9]);
    @(negedge clk);
    chk("bp.drained", {31'd0, bus.out_valid}, 32'd0);
    chk("bp.count", {16'd0, bus.illegal_count}, model_cnt);

    // ---- reset with a word buffered ----
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instr = 32'h00000000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    model_cnt++;
    chk("pre_rst.count", {16'd0, bus.illegal_count}, model_cnt);
    chk("pre_rst.valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst.count",     {16'd0, bus.illegal_count}, 32'd0);
    chk("midrst.illegal",   {31'd0, bus.illegal}, 32'd0);
    chk("midrst.in_ready",  {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("after_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("after_rst.in_ready",  {31'd0, bus.in_ready}, 32'd1);

    // ---- saturation with CNT_W=2 ----
    bus2.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1; bus2.instr = 32'h0000007F;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      chk($sformatf("sat%0d.illegal", k), {31'd0, bus2.illegal}, 32'd1);
      chk($sformatf("sat%0d.count", k), {30'd0, bus2.illegal_count}, (k > 3) ? 32'd3 : k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
